// File: rtl/itcm_banked_if.sv
// Load/fetch bus between the loader/IF stage (master) and the banked ITCM (slave).
interface itcm_banked_if #(
    parameter int unsigned PC_SIZE = 32
);
    logic               wr_en;
    logic [PC_SIZE-1:0] wr_addr;
    logic [3:0]         wr_be;
    logic [31:0]        wr_data;
    logic               rd_req;
    logic [PC_SIZE-1:0] rd_addr;
    logic               rd_ready;
    logic               rd_valid;
    logic [31:0]        rd_data;
    logic               rd_err;

    modport master (
        output wr_en, wr_addr, wr_be, wr_data, rd_req, rd_addr,
        input  rd_ready, rd_valid, rd_data, rd_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_be, wr_data, rd_req, rd_addr,
        output rd_ready, rd_valid, rd_data, rd_err
    );
endinterface

// File: rtl/itcm_banked.sv
// Instruction TCM: four byte-wide banks, byte-enabled write port, registered
// fetch port with misaligned two-word fetch and range/misalign error reporting.
module itcm_banked #(
    parameter int unsigned PC_SIZE        = 32,
    parameter int unsigned DEPTH_WORDS    = 128,
    parameter int unsigned ALLOW_MISALIGN = 1
) (
    input  logic         clk,
    input  logic         rst,
    itcm_banked_if.slave bus
);
    localparam int unsigned WW = PC_SIZE - 2;
    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic {
        S_IDLE,
        S_SECOND
    } state_t;

    // Storage: word-indexed, one byte per bank lane; never reset.
    logic [3:0][7:0] r_mem [DEPTH_WORDS];

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_w;
    logic [AW-1:0]   w_w_nxt;
    logic [1:0]      r_off;
    logic [1:0]      w_off_nxt;
    logic [31:0]     r_lo;
    logic [31:0]     w_lo_nxt;

    logic            r_rd_ready;
    logic            r_rd_valid;
    logic [31:0]     r_rd_data;
    logic            r_rd_err;
    logic            w_ready_nxt;
    logic            w_valid_nxt;
    logic [31:0]     w_data_nxt;
    logic            w_err_nxt;

    logic [WW-1:0]   w_wr_w;
    logic            w_wr_ok;
    logic [WW-1:0]   w_rd_w;
    logic [1:0]      w_rd_off;
    logic            w_rd_mis;
    logic            w_rd_bad;
    logic [AW-1:0]   w_w_inc;
    logic [31:0]     w_word_a;
    logic [31:0]     w_word_b;
    logic [63:0]     w_pair;
    logic            w_unused;

    // Low address bits of the write port only select lanes via wr_be.
    assign w_unused = &{1'b0, bus.wr_addr[1:0]};

    // Address decode for both ports and the two memory read taps.
    always_comb begin
        w_wr_w   = bus.wr_addr[PC_SIZE-1:2];
        w_wr_ok  = bus.wr_en && (w_wr_w < WW'(DEPTH_WORDS));
        w_rd_w   = bus.rd_addr[PC_SIZE-1:2];
        w_rd_off = bus.rd_addr[1:0];
        w_rd_mis = (w_rd_off != 2'd0);
        // Out of range, misalign not allowed, or second word would run past the end.
        w_rd_bad = (w_rd_w >= WW'(DEPTH_WORDS))
                 || (w_rd_mis && (ALLOW_MISALIGN == 0))
                 || (w_rd_mis && (w_rd_w == WW'(DEPTH_WORDS - 1)));
        // Error rule guarantees r_w+1 never exceeds the array, so AW bits suffice.
        w_w_inc  = r_w + AW'(1);
        w_word_a = r_mem[w_rd_w[AW-1:0]];
        w_word_b = r_mem[w_w_inc];
        w_pair   = {w_word_b, r_lo};
    end

    // Byte-lane writes; accepted in every state including reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (bus.wr_be[lane]) begin
                    r_mem[w_wr_w[AW-1:0]][lane] <= bus.wr_data[8*lane +: 8];
                end
            end
        end
    end

    // Fetch FSM state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_w        <= '0;
            r_off      <= '0;
            r_lo       <= '0;
            r_rd_ready <= 1'b1;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_err   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_w        <= w_w_nxt;
            r_off      <= w_off_nxt;
            r_lo       <= w_lo_nxt;
            r_rd_ready <= w_ready_nxt;
            r_rd_valid <= w_valid_nxt;
            r_rd_data  <= w_data_nxt;
            r_rd_err   <= w_err_nxt;
        end
    end

    // Next-state and next-output logic; data/err hold when no response issues.
    always_comb begin
        w_state_nxt = r_state;
        w_w_nxt     = r_w;
        w_off_nxt   = r_off;
        w_lo_nxt    = r_lo;
        w_ready_nxt = r_rd_ready;
        w_valid_nxt = 1'b0;
        w_data_nxt  = r_rd_data;
        w_err_nxt   = r_rd_err;
        case (r_state)
            S_IDLE: begin
                w_ready_nxt = 1'b1;
                if (bus.rd_req) begin
                    if (w_rd_bad) begin
                        w_valid_nxt = 1'b1;
                        w_err_nxt   = 1'b1;
                        w_data_nxt  = '0;
                    end else if (!w_rd_mis) begin
                        w_valid_nxt = 1'b1;
                        w_err_nxt   = 1'b0;
                        w_data_nxt  = w_word_a;
                    end else begin
                        w_w_nxt     = w_rd_w[AW-1:0];
                        w_off_nxt   = w_rd_off;
                        w_lo_nxt    = w_word_a;
                        w_ready_nxt = 1'b0;
                        w_state_nxt = S_SECOND;
                    end
                end
            end
            S_SECOND: begin
                w_valid_nxt = 1'b1;
                w_err_nxt   = 1'b0;
                w_data_nxt  = 32'(w_pair >> {r_off, 3'b000});
                w_ready_nxt = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ready_nxt = 1'b1;
            end
        endcase
    end

    assign bus.rd_ready = r_rd_ready;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_data;
    assign bus.rd_err   = r_rd_err;

endmodule
